// File: rtl/program_counter_if.sv
// program_counter_if: fetch-control bus between the sequencer and the program counter
interface program_counter_if #(
  parameter int WIDTH = 5
);
  logic             sel;
  logic             ld;
  logic             inc;
  logic [WIDTH-1:0] jmp;
  logic [WIDTH-1:0] out;
  modport master (output sel, ld, inc, jmp, input out);
  modport slave  (input sel, ld, inc, jmp, output out);
endinterface

// File: rtl/program_counter.sv
// program_counter: staged PC where inc/ld prepare the next address and sel commits it
module program_counter #(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input logic              clk,
  input logic              rst,
  program_counter_if.slave bus
);
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_pending_nxt;
  // jump target beats increment; increment always rebuilds from the visible PC so repeats do not accumulate
  always_comb w_pending_nxt = bus.ld ? bus.jmp : bus.inc ? r_out + WIDTH'(1) : r_pending;
  // commit copies the pre-edge staged value, so a same-edge ld/inc only shows up at a later sel
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pending <= RESET_ADDR;
      r_out     <= RESET_ADDR;
    end else begin
      r_pending <= w_pending_nxt;
      if (bus.sel) r_out <= r_pending;
    end
  assign bus.out = r_out;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed plan plus random traffic against an arithmetic reference model
module tb_program_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int m_pend = 0;
  int m_out = 0;
  program_counter_if #(.WIDTH(5)) bus ();
  program_counter #(.WIDTH(5), .RESET_ADDR(5'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [4:0] got, input int exp);
    n_tests++;
    if (got !== exp[4:0]) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic s, input logic l, input logic i, input logic [4:0] j, input string tag);
    int old_pend;
    @(negedge clk);
    bus.sel = s; bus.ld = l; bus.inc = i; bus.jmp = j;
    @(posedge clk);
    old_pend = m_pend;
    if (l) m_pend = int'(j);
    else if (i) m_pend = (m_out + 1) % 32;
    if (s) m_out = old_pend;
    #1 check(tag, bus.out, m_out);
  endtask
  task automatic async_reset();
    @(negedge clk);
    bus.sel = 0; bus.ld = 0; bus.inc = 0;
    #2 rst = 1'b1;
    #1 check("async_rst", bus.out, 0);
    m_pend = 0;
    m_out = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    bus.sel = 0; bus.ld = 0; bus.inc = 0; bus.jmp = '0;
    #12 check("reset_hold", bus.out, 0);
    @(negedge clk) rst = 1'b0;
    cyc(1, 0, 0, 5'd0, "reset_sel");
    check("reset_sel_const", bus.out, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 0, 1, 5'd0, "sweep_inc");
      cyc(1, 0, 0, 5'd0, "sweep_sel");
      check("sweep_const", bus.out, k % 32);
    end
    cyc(0, 1, 0, 5'd31, "jump_ld");
    cyc(1, 0, 0, 5'd0, "jump_sel");
    check("jump_const", bus.out, 31);
    cyc(0, 1, 1, 5'd3, "ld_inc");
    cyc(1, 0, 0, 5'd0, "ld_inc_sel");
    check("ld_wins", bus.out, 3);
    async_reset();
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 5'd7, "ld_nocommit");
    check("ld_nocommit_const", bus.out, 0);
    cyc(1, 0, 0, 5'd0, "ld_commit");
    check("ld_commit_const", bus.out, 7);
    cyc(0, 1, 0, 5'd4, "set4");
    cyc(1, 0, 0, 5'd0, "set4_sel");
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 5'd0, "idem_inc");
    cyc(1, 0, 0, 5'd0, "idem_sel");
    check("idem_const", bus.out, 5);
    cyc(1, 0, 0, 5'd0, "sel_hold");
    check("sel_hold_const", bus.out, 5);
    cyc(1, 1, 0, 5'd20, "sel_ld_same");
    check("sel_ld_old", bus.out, 5);
    cyc(1, 0, 0, 5'd0, "sel_ld_later");
    check("sel_ld_new", bus.out, 20);
    cyc(0, 1, 0, 5'd9, "stage9");
    async_reset();
    cyc(1, 0, 0, 5'd0, "midrst_sel");
    check("midrst_const", bus.out, 0);
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 49) == 0) async_reset();
      else cyc(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom), "random");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 5-bit program counter for the simple RISC CPU; supplies the instruction address `out` to instruction memory.
- Next address is staged in an internal `pending` register by increment (`inc`) or jump load (`ld`).
- The visible PC `out` is updated from `pending` only when `sel` commits it, so fetch control decides when the address changes.

Parameters:
- WIDTH, 5, address width of `jmp`, `pending` and `out`.
- RESET_ADDR, 0, value of `pending` and `out` after reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  1  commit strobe; `out` takes `pending` at the clock edge.
- ld  input  1  load jump target into `pending`.
- inc  input  1  stage `out + 1` into `pending`.
- jmp  input  WIDTH  jump target address.
- out  output  WIDTH  current program counter, registered.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (rst). While rst=1, `pending` and `out` are forced to RESET_ADDR immediately, with no clock needed.
- Deassertion of rst takes effect on the next rising edge.
- `pending` update at each rising clk edge when rst=0, in priority order:
  - ld=1: `pending <= jmp`.
  - else inc=1: `pending <= out + 1`, modulo 2^WIDTH, so 31 wraps to 0 with no carry out.
  - else `pending` holds.
- `out` update at each rising clk edge when rst=0:
  - sel=1: `out <= pending`, using the value of `pending` before this edge's update.
  - sel=0: `out` holds.
- Simultaneous events:
  - ld and inc together: ld wins.
  - sel with ld or inc at the same edge: `out` gets the old `pending`; the new staged value becomes visible only at a later sel.
- Repeated inc without sel is idempotent: `pending` stays `out + 1` and does not accumulate.
- ld=1 with sel=0 leaves `out` unchanged indefinitely; `jmp` is sampled only on edges where ld=1.
- sel held high with no ld/inc: `out` re-copies an unchanged `pending`, so the value is stable.
- Latency:
  - inc/ld to `pending`: 1 edge.
  - `pending` to `out`: 1 further edge with sel=1.
  - Minimum increment-to-visible: 2 edges.
- No combinational path from any input to `out`; `out` is a pure register.
- Reset mid-operation discards any staged value; after reset, sel alone gives `out` = RESET_ADDR.
- All inputs are synchronous to clk; setup/hold is the integrator's responsibility.

Test Plan:
- Reset: rst=1 asynchronously between edges -> `out` = 0 immediately. Release, pulse sel -> `out` remains 0.
- Increment sweep: 31 iterations of {inc=1 one edge, then sel=1 one edge} -> `out` steps 1,2,…,31. One more inc+sel -> `out` = 0 (wrap).
- Jump load: ld=1, jmp=5'b11111, one edge, then sel=1 -> `out` = 31. Then ld=1 with inc=1 at the same edge -> `pending` = `jmp`, not `out + 1`.
- Load without commit: after reset, jmp=5'b00111, ld=1, sel=0 for several edges -> `out` stays 0. Then sel=1 -> `out` = 7 on the next edge.
- Idempotent inc: `out` = 4, inc=1 for 3 edges, sel=0, then sel=1 -> `out` = 5, not 7.
- Reset mid-operation: stage `pending` = 9 via ld, assert rst before sel -> `out` = 0 and `pending` = 0. Then sel -> `out` = 0.
